// File: rtl/mips_cpu_mem_align.sv
// mips_cpu_mem_align: bridges CPU byte/halfword/word loads and stores onto a
// word-only little-endian memory bus with wait-request and no byte enables.
// Sub-word stores become read-modify-write; LWL/LWR merge with the old rt.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op/req_addr       MIPS opcode and byte address
//   req_wdata/req_rt_old  store data and current rt (LWL/LWR merge)
//   resp_valid/rdata/err  one-cycle completion pulse with result or error
//   mem_*                 word memory bus (address, read/write strobes,
//                         write data, read data, wait-request)
module mips_cpu_mem_align (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  state, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rt_q, rt_d;

  logic        resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [31:0] resp_rdata_d, mem_address_d, mem_writedata_d;

  logic [4:0]  sh_byte, sh_half, sh_lwl;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_result, merge_word;
  logic        is_rmw_store;

  // Misalignment / unsupported-opcode check, evaluated on the raw request.
  function automatic logic op_err(input logic [5:0] op, input logic [1:0] b);
    case (op)
      OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: op_err = 1'b0;
      OP_LH, OP_LHU, OP_SH:                op_err = b[0];
      OP_LW, OP_SW:                        op_err = (b != 2'd0);
      default:                             op_err = 1'b1;
    endcase
  endfunction

  // Held off during reset so no request is taken while the FSM is clearing.
  assign req_ready = (state == S_IDLE) && !reset;

  // Load extraction and RMW merge on the captured read word.
  always_comb begin
    sh_byte      = 5'({off_q, 3'b000});
    sh_half      = 5'({off_q[1], 4'b0000});
    sh_lwl       = 5'({2'd3 - off_q, 3'b000});
    rd_byte      = 8'(mem_readdata >> sh_byte);
    rd_half      = 16'(mem_readdata >> sh_half);
    is_rmw_store = (op_q == OP_SB) || (op_q == OP_SH);
    case (op_q)
      OP_LB:   load_result = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_result = {24'd0, rd_byte};
      OP_LH:   load_result = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_result = {16'd0, rd_half};
      OP_LWL:  load_result = (mem_readdata << sh_lwl)
                           | (rt_q & ~(32'hFFFF_FFFF << sh_lwl));
      OP_LWR:  load_result = (mem_readdata >> sh_byte)
                           | (rt_q & ~(32'hFFFF_FFFF >> sh_byte));
      default: load_result = mem_readdata;
    endcase
    if (op_q == OP_SH)
      merge_word = (mem_readdata & ~(32'h0000_FFFF << sh_half))
                 | (32'(wdata_q[15:0]) << sh_half);
    else
      merge_word = (mem_readdata & ~(32'h0000_00FF << sh_byte))
                 | (32'(wdata_q[7:0]) << sh_byte);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state;
    op_d            = op_q;
    off_d           = off_q;
    wdata_d         = wdata_q;
    rt_d            = rt_q;
    resp_valid_d    = 1'b0;
    resp_err_d      = resp_err;
    resp_rdata_d    = resp_rdata;
    mem_address_d   = mem_address;
    mem_read_d      = mem_read;
    mem_write_d     = mem_write;
    mem_writedata_d = mem_writedata;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          op_d          = req_op;
          off_d         = req_addr[1:0];
          wdata_d       = req_wdata;
          rt_d          = req_rt_old;
          mem_address_d = {req_addr[31:2], 2'b00};
          if (op_err(req_op, req_addr[1:0])) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
            state_d      = S_RESP;
          end else if (req_op == OP_SW) begin
            mem_write_d     = 1'b1;
            mem_writedata_d = req_wdata;
            state_d         = S_WRITE;
          end else begin
            mem_read_d = 1'b1;
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        if (!mem_waitrequest) begin
          mem_read_d = 1'b0;
          if (is_rmw_store) begin
            mem_write_d     = 1'b1;
            mem_writedata_d = merge_word;
            state_d         = S_WRITE;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_result;
            state_d      = S_RESP;
          end
        end
      end
      S_WRITE: begin
        if (!mem_waitrequest) begin
          mem_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'd0;
          state_d      = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      op_q          <= 6'd0;
      off_q         <= 2'd0;
      wdata_q       <= 32'd0;
      rt_q          <= 32'd0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= 32'd0;
      mem_address   <= 32'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= 32'd0;
    end else begin
      state         <= state_d;
      op_q          <= op_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      rt_q          <= rt_d;
      resp_valid    <= resp_valid_d;
      resp_err      <= resp_err_d;
      resp_rdata    <= resp_rdata_d;
      mem_address   <= mem_address_d;
      mem_read      <= mem_read_d;
      mem_write     <= mem_write_d;
      mem_writedata <= mem_writedata_d;
    end
  end

endmodule

// File: doc/mips_cpu_mem_align.md
# mips_cpu_mem_align

Load/store alignment bridge between the CPU data port and a word-only data memory. It accepts one memory request at a time, tagged with a byte address and a MIPS load/store opcode, and issues the matching word transactions on a memory bus that has a wait-request but no byte enables. It returns sign- or zero-extended load data, and LWL/LWR merged data. Byte and halfword stores become read-modify-write sequences. The memory is little-endian: byte k of a word occupies bits [8k+7:8k].

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready` at a rising edge.
- req_op  in  6  MIPS opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011.
- req_addr  in  32  byte address (rs + sign-extended offset).
- req_wdata  in  32  store data (rt).
- req_rt_old  in  32  current rt value, used for the LWL/LWR merge.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load result (0 for stores and errors).
- resp_err  out  1  misaligned access or unsupported opcode; valid with resp_valid.
- mem_address  out  32  word address `{req_addr[31:2], 2'b00}`.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  full word to write.
- mem_readdata  in  32  read data, valid in the cycle where `mem_read && !mem_waitrequest`.
- mem_waitrequest  in  1  stall; strobes, address and write data are held while it is high.

## Operation
- States: IDLE, READ, WRITE, RESP. Every output is registered except req_ready, which equals (state == IDLE).
- On accept, latch op, byte offset b = req_addr[1:0], the word address, req_wdata and req_rt_old.
- Error check at accept:
  - LH/LHU/SH with b[0]=1 is an error.
  - LW/SW with b≠0 is an error.
  - Any opcode outside the list is an error.
  - On error: IDLE→RESP with resp_err=1 and resp_rdata=0. No bus strobe is raised.
- Loads: IDLE→READ. On the first READ cycle with waitrequest low, capture word W and go to RESP. Result by opcode:
  - LB: sign-extend W byte b. LBU: zero-extend W byte b.
  - LH: sign-extend W[16b'+15:16b'], where b' = b[1]. LHU: zero-extend the same halfword.
  - LW: W.
  - LWL: (W << 8(3−b)) | (rt_old & ((1<<8(3−b))−1)).
  - LWR: (W >> 8b) | (rt_old & ~(32'hFFFFFFFF >> 8b)).
  - LWL/LWR ignore alignment and never raise an error.
- SW: IDLE→WRITE with mem_writedata = req_wdata.
- SB/SH: IDLE→READ, then WRITE with W modified:
  - SB replaces byte b with wdata[7:0].
  - SH replaces halfword b' with wdata[15:0].
  - All other bytes are preserved.
- WRITE leaves on the first cycle with waitrequest low and goes to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.

## Timing
- Reset values: state IDLE, mem_read=0, mem_write=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_writedata=0. req_ready is 0 during the reset cycle and 1 after it.
- Latency with zero wait states, where accept is at edge 0:
  - Loads: mem_read is high during cycle 1; resp_valid is high in cycle 2.
  - SW: mem_write is high during cycle 1; resp_valid is high in cycle 2.
  - SB/SH: mem_read in cycle 1, mem_write in cycle 2, resp_valid in cycle 3.
  - Errors: resp_valid in cycle 1.
- Each wait-request cycle adds exactly one cycle. mem_read and mem_write are never high together. mem_address is constant from the first strobe to the end of the transaction.
- mem_read drops on the edge after read data is captured; mem_write drops on the edge after the write is accepted.
- A new request can be accepted in the cycle after resp_valid, so back-to-back requests are separated by ≥1 idle cycle.
- req_valid in a non-IDLE state is ignored. Request inputs are sampled only on accept.
- Reset mid-transaction: the transaction is aborted. All strobes and resp_valid are 0 after the reset edge, and no response is issued.

## Test plan
- LB at address 0x1003, memory word 0x80FF1234 → single read of 0x1000; resp_rdata=0xFFFFFF80 in cycle 2. The same access as LBU → 0x00000080.
- SB at address 0x2001, wdata 0x000000AB, memory word 0x11223344 → read then write of 0x1122AB44; resp_valid in cycle 3; mem_read and mem_write are never high together.
- LWL at offset 1 with W=0xAABBCCDD and rt_old=0x11223344 → 0xCCDD3344. LWR at offset 2 with the same inputs → 0x1122AABB.
- LW at address 0x3002 → resp_err=1 and resp_rdata=0 in cycle 1; mem_read is never asserted. Opcode 001001 → resp_err=1.
- SW with mem_waitrequest held high for 3 cycles → mem_write held for 4 cycles; address and data are stable throughout; resp_valid 5 cycles after accept.
- Reset asserted while in READ → mem_read=0 and state IDLE after the edge; no resp_valid; the next request then completes normally.
